// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time for a burst of words
// into a single downstream write port. Define BURST_LIMIT_EN to cap bursts at MAX_BURST.
module burst_arbiter_lane #(
  parameter int IDX = 0,
  parameter int LW  = 4
) (
  input  logic          granted,
  input  logic [LW-1:0] cur,
  input  logic          valid,
  input  logic          full,
  output logic          ready
);
  assign ready = granted && (cur == LW'(IDX)) && valid && !full;
endmodule

module burst_arbiter #(
  parameter int N         = 16,
  parameter int REQ_SIZE  = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 Valid,
  input  logic [N-1:0][REQ_SIZE-1:0]   Data_in,
  input  logic                         full,
  output logic [N-1:0]                 Ready,
  output logic [REQ_SIZE-1:0]          Data_out,
  output logic                         wr_en,
  output logic [3:0]                   grant_idx,
  output logic                         busy
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("burst_arbiter: N must be a power of two in 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("burst_arbiter: MAX_BURST must be in 1..15");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [3:0]    ptr, cur, cnt;
  logic [LW-1:0] cur_l, ptr_l, nxt_l, pick, idx;
  logic          granted, valid_cur, xfer, last;

  assign cur_l     = cur[LW-1:0];
  assign ptr_l     = ptr[LW-1:0];
  assign nxt_l     = cur_l + LW'(1);
  assign granted   = (state == GRANT);
  assign valid_cur = Valid[cur_l];
  assign xfer      = Ready[cur_l];
  assign grant_idx = cur;
  assign busy      = granted;

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    pick = ptr_l;
    idx  = ptr_l;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_l + LW'(k);
      if (Valid[idx]) pick = idx;
    end
  end

`ifdef BURST_LIMIT_EN
  assign last = (cnt == 4'(MAX_BURST - 1));
`else
  assign last = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    burst_arbiter_lane #(.IDX(i), .LW(LW)) u_lane (
      .granted (granted),
      .cur     (cur_l),
      .valid   (Valid[i]),
      .full    (full),
      .ready   (Ready[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cur      <= '0;
      cnt      <= '0;
      Data_out <= '0;
      wr_en    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (|Valid) begin
            cur   <= 4'(pick);
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!valid_cur) begin
            state <= IDLE;
            ptr   <= 4'(nxt_l);
          end else if (xfer) begin
            Data_out <= Data_in[cur_l];
            wr_en    <= 1'b1;
            cnt      <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
            if (last) begin
              state <= IDLE;
              ptr   <= 4'(nxt_l);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_arbiter.sv
// Self-checking bench for burst_arbiter: vector table plus scoreboard on Data_out.
module tb_burst_arbiter;
  localparam int N = 16;
  localparam int W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         Valid = '0;
  logic [N-1:0][W-1:0]  Data_in = '0;
  logic                 full = 1'b0;
  logic [N-1:0]         Ready;
  logic [W-1:0]         Data_out;
  logic                 wr_en;
  logic [3:0]           grant_idx;
  logic                 busy;

  burst_arbiter #(.N(N), .REQ_SIZE(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .Data_in(Data_in), .full(full),
    .Ready(Ready), .Data_out(Data_out), .wr_en(wr_en), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic        fu;
    logic        rs;
    logic [15:0] er;
    logic [3:0]  eg;
    logic        eb;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] sb[$];
  logic         pend = 1'b0;
  logic [W-1:0] last_do = '0;
  logic [11:0]  cyc = '0;
  int           tests = 0;
  int           fails = 0;
  int           row = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic fu, input logic rs,
                              input logic [15:0] er, input logic [3:0] eg, input logic eb);
    vec_t v;
    v.va = va; v.fu = fu; v.rs = rs; v.er = er; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  task automatic add(input logic [15:0] va, input logic fu, input logic rs,
                     input logic [15:0] er, input logic [3:0] eg, input logic eb);
    tbl.push_back(mk(va, fu, rs, er, eg, eb));
  endtask

  task automatic drive_data();
    cyc++;
    for (int i = 0; i < N; i++) Data_in[i] = {4'(i), cyc};
  endtask

  // Called just after a rising edge; checks at the falling edge, returns after the next rise.
  task automatic apply(input vec_t v);
    logic [W-1:0] exp;
    rst_n = !v.rs;
    Valid = v.va;
    full  = v.fu;
    drive_data();
    @(negedge clk);
    chk("ready", 32'(Ready), 32'(v.er));
    chk("grant_idx", 32'(grant_idx), 32'(v.eg));
    chk("busy", 32'(busy), 32'(v.eb));
    chk("wr_en", 32'(wr_en), 32'(pend && !v.rs));
    if (pend && !v.rs) begin
      exp = sb.pop_front();
      chk("data_out", 32'(Data_out), 32'(exp));
      last_do = exp;
    end else begin
      if (v.rs) begin
        sb.delete();
        last_do = '0;
      end
      chk("data_hold", 32'(Data_out), 32'(last_do));
    end
    pend = !v.rs && (v.er != '0);
    if (pend) sb.push_back(Data_in[v.eg]);
    row++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] va, input logic fu, input logic rs,
                      input logic [15:0] er, input logic [3:0] eg, input logic eb);
    apply(mk(va, fu, rs, er, eg, eb));
  endtask

  initial begin
    // reset state with every requester asking
    add(16'hFFFF, 0, 1, 16'h0000, 4'd0, 0);
    // single requester 0 held for six transfers
    add(16'h0001, 0, 0, 16'h0000, 4'd0, 0);
`ifdef BURST_LIMIT_EN
    repeat (4) add(16'h0001, 0, 0, 16'h0001, 4'd0, 1);
    add(16'h0001, 0, 0, 16'h0000, 4'd0, 0);
    repeat (2) add(16'h0001, 0, 0, 16'h0001, 4'd0, 1);
`else
    repeat (6) add(16'h0001, 0, 0, 16'h0001, 4'd0, 1);
`endif
    add(16'h0000, 0, 0, 16'h0000, 4'd0, 1);
    add(16'h0000, 0, 0, 16'h0000, 4'd0, 0);
    // requesters 3 and 5 from ptr=0: 3, then 5, then 3
    add(16'h0000, 0, 1, 16'h0000, 4'd0, 0);
    add(16'h0028, 0, 0, 16'h0000, 4'd0, 0);
    add(16'h0028, 0, 0, 16'h0008, 4'd3, 1);
    add(16'h0028, 0, 0, 16'h0008, 4'd3, 1);
    add(16'h0020, 0, 0, 16'h0000, 4'd3, 1);
    add(16'h0028, 0, 0, 16'h0000, 4'd3, 0);
    add(16'h0028, 0, 0, 16'h0020, 4'd5, 1);
    add(16'h0028, 0, 0, 16'h0020, 4'd5, 1);
    add(16'h0008, 0, 0, 16'h0000, 4'd5, 1);
    add(16'h0028, 0, 0, 16'h0000, 4'd5, 0);
    add(16'h0028, 0, 0, 16'h0008, 4'd3, 1);
    add(16'h0000, 0, 0, 16'h0000, 4'd3, 1);
    add(16'h0000, 0, 0, 16'h0000, 4'd3, 0);
    // full stall at cnt=2 on requester 2; non-owner Valid noise ignored
    add(16'h0004, 0, 0, 16'h0000, 4'd3, 0);
    add(16'hF0F4, 0, 0, 16'h0004, 4'd2, 1);
    add(16'h0005, 0, 0, 16'h0004, 4'd2, 1);
    repeat (3) add(16'h0FF4, 1, 0, 16'h0000, 4'd2, 1);
    add(16'h0004, 0, 0, 16'h0004, 4'd2, 1);
    add(16'h0104, 0, 0, 16'h0004, 4'd2, 1);
`ifdef BURST_LIMIT_EN
    add(16'h0000, 0, 0, 16'h0000, 4'd2, 0);
`else
    add(16'h0000, 0, 0, 16'h0000, 4'd2, 1);
`endif
    add(16'h0000, 0, 0, 16'h0000, 4'd2, 0);
    // owner 4 drops at cnt=1; ptr moves to 5 so 5 beats 3
    add(16'h0010, 0, 0, 16'h0000, 4'd2, 0);
    add(16'h0010, 0, 0, 16'h0010, 4'd4, 1);
    add(16'h0028, 0, 0, 16'h0000, 4'd4, 1);
    add(16'h0028, 0, 0, 16'h0000, 4'd4, 0);
    add(16'h0028, 0, 0, 16'h0020, 4'd5, 1);
    add(16'h0000, 0, 0, 16'h0000, 4'd5, 1);
    add(16'h0000, 0, 0, 16'h0000, 4'd5, 0);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // all requesters active
    step(16'hFFFF, 0, 1, 16'h0000, 4'd0, 0);
`ifdef BURST_LIMIT_EN
    for (int k = 0; k < 16; k++) begin
      step(16'hFFFF, 0, 0, 16'h0000, (k == 0) ? 4'd0 : 4'(k - 1), 0);
      repeat (4) step(16'hFFFF, 0, 0, 16'h0001 << k, 4'(k), 1);
    end
    step(16'hFFFF, 0, 0, 16'h0000, 4'd15, 0);
    step(16'hFFFF, 0, 0, 16'h0001, 4'd0, 1);
`else
    step(16'hFFFF, 0, 0, 16'h0000, 4'd0, 0);
    repeat (20) step(16'hFFFF, 0, 0, 16'h0001, 4'd0, 1);
`endif
    step(16'h0000, 0, 0, 16'h0000, 4'd0, 1);
    step(16'h0000, 0, 0, 16'h0000, 4'd0, 0);

    // asynchronous reset during the second transfer of a burst
    step(16'h0000, 0, 1, 16'h0000, 4'd0, 0);
    step(16'h0002, 0, 0, 16'h0000, 4'd0, 0);
    step(16'h0002, 0, 0, 16'h0002, 4'd1, 1);
    Valid = 16'h0002;
    full  = 1'b0;
    drive_data();
    #2;
    chk("mid_ready", 32'(Ready), 32'h0002);
    chk("mid_wr_en", 32'(wr_en), 32'h1);
    chk("mid_data_out", 32'(Data_out), 32'(sb.pop_front()));
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(Ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_data_out", 32'(Data_out), 32'h0);
    chk("rst_grant_idx", 32'(grant_idx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    sb.delete();
    pend = 1'b0;
    last_do = '0;
    @(posedge clk);
    #1;
    step(16'h0003, 0, 0, 16'h0000, 4'd0, 0);
    step(16'h0003, 0, 0, 16'h0001, 4'd0, 1);
    step(16'h0000, 0, 0, 16'h0000, 4'd0, 1);
    step(16'h0000, 0, 0, 16'h0000, 4'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 Parameter: N, 16, number of requesters (banks), power of two, 2..16.
REQ-002 Parameter: REQ_SIZE, 16, request word width in bits.
REQ-003 Parameter: MAX_BURST, 4, maximum transfers per grant, 1..15.
REQ-004 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: Valid, input, N, per-requester request pending.
REQ-007 Port: Data_in, input, N x REQ_SIZE, per-requester request word.
REQ-008 Port: full, input, 1, downstream buffer cannot accept a word this cycle.
REQ-009 Port: Ready, output, N, per-requester accept strobe (combinational).
REQ-010 Port: Data_out, output, REQ_SIZE, registered accepted word.
REQ-011 Port: wr_en, output, 1, registered write strobe qualifying Data_out.
REQ-012 Port: grant_idx, output, 4, index of the current grant owner.
REQ-013 Port: busy, output, 1, high while state is GRANT.

Function
REQ-014 FSM states: IDLE and GRANT; registers: ptr (round-robin start, 4 bits), cur (owner), cnt (burst count, 4 bits).
REQ-015 IDLE: if Valid is nonzero, cur <= first i with Valid[i]=1 searching ptr, ptr+1, ... mod N; cnt <= 0; next state GRANT. Otherwise remain in IDLE.
REQ-016 Ready[i] = (state==GRANT) & (i==cur) & Valid[i] & !full; all other Ready bits are 0.
REQ-017 Transfer: a cycle with Ready[cur]=1. On a transfer, Data_out <= Data_in[cur], wr_en <= 1, and cnt <= cnt+1. Otherwise wr_en <= 0 and Data_out holds.
REQ-018 Latency: the word accepted in cycle t appears on Data_out with wr_en=1 in cycle t+1.
REQ-019 GRANT exit on a transfer with cnt==MAX_BURST-1: next state IDLE, ptr <= (cur+1) mod N.
REQ-020 GRANT exit when Valid[cur]=0: next state IDLE, ptr <= (cur+1) mod N, no transfer.
REQ-021 full=1 in GRANT: no transfer; cnt, cur and the state hold; the stall duration is unbounded.
REQ-022 A requester switch always costs exactly one IDLE bubble cycle.
REQ-023 A single active requester is re-granted after each IDLE bubble; there is no deadlock.
REQ-024 Valid changes on non-owner requesters during GRANT have no effect until the next IDLE.
REQ-025 grant_idx = cur at all times.

Reset
REQ-026 When rst_n=0: state=IDLE, ptr=0, cur=0, cnt=0, Data_out=0, wr_en=0. Ready, grant_idx and busy are therefore 0.
REQ-027 Reset asserted mid-burst discards the burst immediately; no wr_en pulse follows the deassertion of reset.

Configuration
REQ-028 With macro BURST_LIMIT_EN defined: the MAX_BURST exit of REQ-019 is active.
REQ-029 Without BURST_LIMIT_EN: REQ-019 is removed; the grant holds until Valid[cur]=0 (REQ-020). cnt still counts and saturates at 15.

Verification
REQ-030 Bench: Valid=16'h0001, full=0, Valid[0] held 6 cycles -> with the macro: 4 transfers, 1 bubble, 2 transfers. Without the macro: 6 consecutive wr_en pulses.
REQ-031 Bench: Valid=16'hFFFF held, macro on -> grant_idx sequence 0,1,2,...,15,0. Each owner gets 4 transfers followed by a 1-cycle bubble.
REQ-032 Bench: Valid=16'h0028, ptr=0 -> requester 3 is granted first, then requester 5, then requester 3.
REQ-033 Bench: full=1 for 3 cycles mid-burst, at cnt=2 -> Ready=0 and wr_en=0 for 3 cycles. The burst then resumes with 2 remaining transfers; Data_out order is preserved.
REQ-034 Bench: Valid[cur] drops at cnt=1 -> IDLE next cycle, ptr=cur+1, and the next Valid requester is granted.
REQ-035 Bench: rst_n pulsed low during the second transfer of a burst -> all outputs are 0 immediately. After release, arbitration restarts from requester 0.
